// File: rtl/param_sync_counter.sv
// Purpose : parameterised up/down counter over 0..MAX_VAL with wrap or saturate
//           at the range ends, clamped parallel load, a wrap pulse and a sticky
//           overflow flag.
// Latency : one clock from sampled rst/load/en to q, wrap and ovf. tc is
//           combinational from q and up_dn.
// Backpressure: none. The counter accepts its controls every cycle and never stalls.
//
// Ports
//   clk      : single clock; all state updates on the rising edge
//   rst      : synchronous active-high reset (q=0, wrap=0, ovf=0)
//   en       : count enable
//   up_dn    : direction, 1 = up, 0 = down
//   sat      : boundary mode, 1 = saturate at the range end, 0 = wrap around
//   load     : parallel load strobe; has priority over en
//   load_val : value to load; values above MAX_VAL are clamped to MAX_VAL
//   clr_ovf  : clears ovf; a boundary event on the same edge wins
//   q        : registered count, always within 0..MAX_VAL
//   tc       : terminal count for the current direction
//   wrap     : one-cycle pulse after a wrap-around (sat=0 boundary event)
//   ovf      : sticky flag, set by any boundary event in either sat mode
module param_sync_counter #(
  parameter int WIDTH   = 8,
  parameter int MAX_VAL = 2**WIDTH-1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up_dn,
  input  logic             sat,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             clr_ovf,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             wrap,
  output logic             ovf
);

  // MAX_VAL is an int, so WIDTH is capped at 31. This keeps the full range
  // representable in the parameter.
  if (WIDTH < 1 || WIDTH > 31) begin : g_bad_width
    $error("param_sync_counter: WIDTH=%0d out of range 1..31", WIDTH);
  end

  if (MAX_VAL < 1 || longint'(MAX_VAL) > ((longint'(1) << WIDTH) - 1)) begin : g_bad_max
    $error("param_sync_counter: MAX_VAL=%0d out of range 1..2**%0d-1", MAX_VAL, WIDTH);
  end

  localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(MAX_VAL);
  localparam logic [WIDTH-1:0] ONE_Q = WIDTH'(1);

  logic at_max;
  logic at_zero;

  // A boundary event is an enabled count while sitting on tc. The direction
  // decides which end of the range is the boundary. The same term drives both
  // the tc output and the counting decision, so the two cannot disagree.
  always_comb begin
    at_max  = (q == MAX_Q);
    at_zero = (q == '0);
    tc      = up_dn ? at_max : at_zero;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q    <= '0;
      wrap <= 1'b0;
      ovf  <= 1'b0;
    end else if (load) begin
      // A load is not a boundary event. It leaves ovf alone except for an
      // explicit clear.
      q    <= (load_val > MAX_Q) ? MAX_Q : load_val;
      wrap <= 1'b0;
      if (clr_ovf) begin
        ovf <= 1'b0;
      end
    end else if (en) begin
      if (tc) begin
        // In saturate mode q simply holds. The overflow is still recorded.
        if (!sat) begin
          q <= up_dn ? '0 : MAX_Q;
        end
        wrap <= ~sat;
        ovf  <= 1'b1;
      end else begin
        // Not on the boundary, so the step stays inside 0..MAX_VAL. This holds
        // even when MAX_VAL is below the natural top of the register.
        q    <= up_dn ? (q + ONE_Q) : (q - ONE_Q);
        wrap <= 1'b0;
        if (clr_ovf) begin
          ovf <= 1'b0;
        end
      end
    end else begin
      wrap <= 1'b0;
      if (clr_ovf) begin
        ovf <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_param_sync_counter.sv
// Purpose : self-checking bench for param_sync_counter (WIDTH=4/MAX_VAL=9 and
//           WIDTH=3 default range), directed steps plus randomized traffic.
// Latency : checks sample 1 time unit after each rising edge.
// Backpressure: not applicable.
module tb_param_sync_counter;

  localparam int W    = 4;
  localparam int MAXV = 9;

  logic         clk = 1'b0;
  logic         rst, en, up_dn, sat, load, clr_ovf;
  logic [W-1:0] load_val;
  logic [W-1:0] q;
  logic         tc, wrap, ovf;

  logic         rst3, en3, load3, clr3;
  logic [2:0]   load_val3;
  logic [2:0]   q3;
  logic         tc3, wrap3, ovf3;

  int checks = 0;
  int errors = 0;

  // Reference model state for the main instance.
  int m_q;
  bit m_wrap, m_ovf;

  always #5 clk = ~clk;

  param_sync_counter #(.WIDTH(W), .MAX_VAL(MAXV)) dut (
    .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .sat(sat), .load(load),
    .load_val(load_val), .clr_ovf(clr_ovf), .q(q), .tc(tc), .wrap(wrap), .ovf(ovf)
  );

  param_sync_counter #(.WIDTH(3)) dut3 (
    .clk(clk), .rst(rst3), .en(en3), .up_dn(up_dn), .sat(sat), .load(load3),
    .load_val(load_val3), .clr_ovf(clr3), .q(q3), .tc(tc3), .wrap(wrap3), .ovf(ovf3)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Compares all DUT outputs against the model. tc is derived from the spec
  // rule using the current up_dn.
  task automatic check_model(input string tag);
    bit exp_tc;
    exp_tc = up_dn ? (m_q == MAXV) : (m_q == 0);
    check({tag, ".q"},    32'(q),    32'(m_q));
    check({tag, ".wrap"}, 32'(wrap), 32'(m_wrap));
    check({tag, ".ovf"},  32'(ovf),  32'(m_ovf));
    check({tag, ".tc"},   32'(tc),   32'(exp_tc));
  endtask

  // Applies one set of inputs, advances one edge, and updates the model from
  // the spec rules with modular arithmetic.
  task automatic cycle(input bit r, input bit l, input int lv, input bit e,
                       input bit u, input bit s, input bit c);
    bit hit;
    rst = r; load = l; load_val = W'(lv); en = e; up_dn = u; sat = s; clr_ovf = c;
    @(posedge clk);
    if (r) begin
      m_q = 0; m_wrap = 0; m_ovf = 0;
    end else if (l) begin
      m_q = (lv > MAXV) ? MAXV : lv;
      m_wrap = 0;
      if (c) m_ovf = 0;
    end else begin
      hit = e && (u ? (m_q == MAXV) : (m_q == 0));
      if (e) begin
        if (u) m_q = s ? ((m_q + 1 > MAXV) ? MAXV : m_q + 1) : (m_q + 1) % (MAXV + 1);
        else   m_q = s ? ((m_q == 0) ? 0 : m_q - 1)          : (m_q + MAXV) % (MAXV + 1);
      end
      m_wrap = hit && !s;
      if (hit) m_ovf = 1;
      else if (c) m_ovf = 0;
    end
    #1;
  endtask

  initial begin
    rst = 1; en = 0; up_dn = 1; sat = 0; load = 0; load_val = '0; clr_ovf = 0;
    rst3 = 1; en3 = 0; load3 = 0; clr3 = 0; load_val3 = '0;
    m_q = 0; m_wrap = 0; m_ovf = 0;

    // Reset state, with tc following the direction.
    cycle(1, 0, 0, 0, 0, 0, 0);
    check_model("rst_dn");
    check("rst_dn.tc_lit", 32'(tc), 32'd1);
    cycle(1, 1, 3, 1, 1, 0, 1);
    check_model("rst_up");
    check("rst_up.tc_lit", 32'(tc), 32'd0);

    // The 3-bit default-range instance behaves as a plain 3-bit up counter.
    rst3 = 0; en3 = 1;
    for (int i = 0; i < 9; i++) begin
      cycle(0, 0, 0, 0, 1, 0, 0);
      check($sformatf("w3_cnt%0d.q", i), 32'(q3), 32'((i + 1) % 8));
      check($sformatf("w3_cnt%0d.wrap", i), 32'(wrap3), 32'(i == 7));
    end
    en3 = 0;

    // Counting up with wrap for 12 edges.
    cycle(1, 0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 12; i++) begin
      cycle(0, 0, 0, 1, 1, 0, 0);
      check_model($sformatf("up%0d", i));
      check($sformatf("up%0d.q_lit", i), 32'(q), 32'((i + 1) % 10));
      check($sformatf("up%0d.wrap_lit", i), 32'(wrap), 32'(i == 9));
    end

    // A down wrap from 0, then clearing ovf with the counter idle.
    cycle(0, 1, 0, 0, 0, 0, 0);
    check_model("ld0");
    cycle(0, 0, 0, 1, 0, 0, 0);
    check_model("dn_wrap");
    check("dn_wrap.q_lit", 32'(q), 32'd9);
    cycle(0, 0, 0, 0, 0, 0, 1);
    check_model("clr");
    check("clr.ovf_lit", 32'(ovf), 32'd0);

    // Saturating at MAX_VAL, then reversing direction.
    for (int i = 0; i < 3; i++) begin
      cycle(0, 0, 0, 1, 1, 1, 0);
      check_model($sformatf("sat%0d", i));
    end
    check("sat.ovf_lit", 32'(ovf), 32'd1);
    cycle(0, 0, 0, 1, 0, 1, 0);
    check_model("rev");
    check("rev.q_lit", 32'(q), 32'd8);

    // A clamped load beats the count.
    cycle(0, 1, 12, 1, 1, 0, 0);
    check_model("ld12");
    check("ld12.q_lit", 32'(q), 32'd9);
    cycle(0, 1, 5, 1, 0, 1, 0);
    check_model("ld5");

    // A boundary event beats clr_ovf. Then rst beats load.
    cycle(0, 1, 9, 0, 1, 0, 0);
    cycle(0, 0, 0, 1, 1, 0, 1);
    check_model("bnd_clr");
    check("bnd_clr.ovf_lit", 32'(ovf), 32'd1);
    cycle(1, 1, 3, 1, 1, 0, 1);
    check_model("rst_ld");

    // A reset asserted mid-cycle does not disturb q before the edge.
    cycle(0, 1, 6, 0, 1, 0, 0);
    rst = 1;
    #2;
    check("async_rst.q", 32'(q), 32'd6);
    cycle(1, 0, 0, 0, 1, 0, 0);
    check_model("rst_edge");

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      cycle(($urandom_range(0, 31) == 0), ($urandom_range(0, 7) == 0),
            int'($urandom_range(0, 15)), ($urandom_range(0, 3) != 0),
            1'($urandom), ($urandom_range(0, 2) == 0), ($urandom_range(0, 7) == 0));
      check_model($sformatf("rnd%0d", i));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
